cp_pair_feeder: RTL and testbench

//  Front-end feeder for the CP-correlation path: accepts the complex baseband stream r[k] one sample
//  per in_valid and emits the aligned pair (r[k], r[k-N]) each accepted sample, via an N-deep circular delay.

---
 rtl/cp_pair_feeder.sv | 106 ++++++++++
 tb/tb_cp_pair_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_pair_feeder.sv
// cp_pair_feeder: CP-correlation front end. Pairs each accepted sample r[k]
// with r[k-N] taken from an N_DELAY-deep circular delay buffer, one cycle of
// latency. A small FILL/RUN machine tracks when r[k-N] holds real data.
//
// Build option: define CP_FEEDER_ZERO_FILL_EN to emit pairs during FILL with
// r[k-N] forced to zero. Without it, nothing is emitted until the buffer
// holds N real samples.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | fewer than N_DELAY samples since rst/sync_clear; r[k-N] invalid
// RUN   | buffer primed; every accepted sample emits a true (r[k], r[k-N])
module cp_pair_feeder #(
  parameter  int N_DELAY = 64,
  parameter  int SYM_LEN = 80,
  parameter  int R_W     = 8,
  localparam int PTR_W   = (N_DELAY > 1) ? $clog2(N_DELAY) : 1,
  localparam int IDX_W   = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clear,
  input  logic             in_valid,
  input  logic [R_W-1:0]   in_real,
  input  logic [R_W-1:0]   in_imag,
  output logic [R_W-1:0]   r_k_real,
  output logic [R_W-1:0]   r_k_imag,
  output logic [R_W-1:0]   r_kn_real,
  output logic [R_W-1:0]   r_kn_imag,
  output logic             out_valid,
  output logic             primed,
  output logic [IDX_W-1:0] sample_idx
);

  localparam int FILL_W = PTR_W + 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill_cnt;
  logic [IDX_W-1:0]   idx_cnt;
  logic [2*R_W-1:0]   mem [N_DELAY];
  logic [2*R_W-1:0]   rd_word;
  logic               wr_en;

  // sync_clear wins over a same-cycle sample, so that sample never enters the buffer
  assign wr_en   = in_valid && !sync_clear && !rst;
  assign rd_word = mem[wr_ptr];

  // Delay buffer: no reset, validity is tracked by fill_cnt/state; the old word
  // at wr_ptr is read (r[k-N]) on the same edge it is overwritten with r[k]
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_real, in_imag};
  end

  // Priming FSM, pointers and registered output pair
  always_ff @(posedge clk) begin
    if (rst || sync_clear) begin
      state      <= FILL;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      idx_cnt    <= '0;
      r_k_real   <= '0;
      r_k_imag   <= '0;
      r_kn_real  <= '0;
      r_kn_imag  <= '0;
      out_valid  <= 1'b0;
      primed     <= 1'b0;
      sample_idx <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        wr_ptr  <= (wr_ptr == PTR_W'(N_DELAY - 1)) ? '0 : wr_ptr + 1'b1;
        idx_cnt <= (idx_cnt == IDX_W'(SYM_LEN - 1)) ? '0 : idx_cnt + 1'b1;
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            primed   <= 1'b0;
            // the Nth sample completes priming; the next one reads true data
            if (fill_cnt == FILL_W'(N_DELAY - 1)) state <= RUN;
`ifdef CP_FEEDER_ZERO_FILL_EN
            out_valid  <= 1'b1;
            r_k_real   <= in_real;
            r_k_imag   <= in_imag;
            r_kn_real  <= '0;
            r_kn_imag  <= '0;
            sample_idx <= idx_cnt;
`endif
          end
          RUN: begin
            out_valid  <= 1'b1;
            primed     <= 1'b1;
            r_k_real   <= in_real;
            r_k_imag   <= in_imag;
            r_kn_real  <= rd_word[2*R_W-1:R_W];
            r_kn_imag  <= rd_word[R_W-1:0];
            sample_idx <= idx_cnt;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp_pair_feeder.sv
// Directed bench for cp_pair_feeder: two instances (N=64 and N=48, SYM_LEN=80)
// share one input stream; ramp inputs make expected pairs simple to derive.
module tb_cp_pair_feeder;

  localparam int R_W = 8;
`ifdef CP_FEEDER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sync_clear = 1'b0;
  logic           in_valid = 1'b0;
  logic [R_W-1:0] in_real = '0;
  logic [R_W-1:0] in_imag = '0;

  logic [R_W-1:0] a_rk_re, a_rk_im, a_rkn_re, a_rkn_im;
  logic           a_valid, a_primed;
  logic [6:0]     a_idx;
  logic [R_W-1:0] b_rk_re, b_rk_im, b_rkn_re, b_rkn_im;
  logic           b_valid, b_primed;
  logic [6:0]     b_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp_pair_feeder #(.N_DELAY(64), .SYM_LEN(80), .R_W(R_W)) dut_a (
    .clk(clk), .rst(rst), .sync_clear(sync_clear), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag),
    .r_k_real(a_rk_re), .r_k_imag(a_rk_im), .r_kn_real(a_rkn_re), .r_kn_imag(a_rkn_im),
    .out_valid(a_valid), .primed(a_primed), .sample_idx(a_idx));

  cp_pair_feeder #(.N_DELAY(48), .SYM_LEN(80), .R_W(R_W)) dut_b (
    .clk(clk), .rst(rst), .sync_clear(sync_clear), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag),
    .r_k_real(b_rk_re), .r_k_imag(b_rk_im), .r_kn_real(b_rkn_re), .r_kn_imag(b_rkn_im),
    .out_valid(b_valid), .primed(b_primed), .sample_idx(b_idx));

  // apply inputs, take one edge, sample 1 time unit later
  task automatic drive(input logic v, input logic [R_W-1:0] re, input logic [R_W-1:0] im,
                       input logic sc);
    in_valid   = v;
    in_real    = re;
    in_imag    = im;
    sync_clear = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, R_W'($urandom), R_W'($urandom), (c == 1));
      n_tests++;
      if ({a_valid, a_primed, a_rk_re, a_rk_im, a_rkn_re, a_rkn_im, a_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_a c=%0d got v=%b p=%b rk=%h/%h rkn=%h/%h idx=%0d exp all 0",
                 c, a_valid, a_primed, a_rk_re, a_rk_im, a_rkn_re, a_rkn_im, a_idx);
      end
      n_tests++;
      if ({b_valid, b_primed, b_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_b c=%0d got v=%b p=%b idx=%0d exp 0", c, b_valid, b_primed, b_idx);
      end
    end
    rst = 1'b0;
  endtask

  // continuous ramp on the N=64 instance
  task automatic test_ramp();
    logic ev;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, R_W'(k), R_W'(-k), 1'b0);
      ev = ZF || (k >= 64);
      n_tests++;
      if (a_valid !== ev) begin
        n_fail++;
        $display("FAIL ramp_valid k=%0d got %b exp %b", k, a_valid, ev);
      end
      if (ev) begin
        n_tests++;
        if ({a_rk_re, a_rk_im} !== {R_W'(k), R_W'(-k)}) begin
          n_fail++;
          $display("FAIL ramp_rk k=%0d got %h/%h exp %h/%h", k, a_rk_re, a_rk_im, R_W'(k), R_W'(-k));
        end
        n_tests++;
        if ({a_rkn_re, a_rkn_im} !== ((k >= 64) ? {R_W'(k - 64), R_W'(64 - k)} : 16'h0)) begin
          n_fail++;
          $display("FAIL ramp_rkn k=%0d got %h/%h exp %h/%h", k, a_rkn_re, a_rkn_im,
                   (k >= 64) ? R_W'(k - 64) : R_W'(0), (k >= 64) ? R_W'(64 - k) : R_W'(0));
        end
        n_tests++;
        if (a_primed !== (k >= 64)) begin
          n_fail++;
          $display("FAIL ramp_primed k=%0d got %b exp %b", k, a_primed, (k >= 64));
        end
        n_tests++;
        if (a_idx !== 7'(k % 80)) begin
          n_fail++;
          $display("FAIL ramp_idx k=%0d got %0d exp %0d", k, a_idx, k % 80);
        end
      end
    end
  endtask

  // same ramp, one accept every third cycle
  task automatic test_gapped();
    int k;
    logic ev;
    do_reset();
    k = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 3 == 0) begin
        drive(1'b1, R_W'(k), R_W'(-k), 1'b0);
        ev = ZF || (k >= 64);
        n_tests++;
        if (a_valid !== ev) begin
          n_fail++;
          $display("FAIL gap_valid k=%0d got %b exp %b", k, a_valid, ev);
        end
        if (ev) begin
          n_tests++;
          if ({a_rk_re, a_rk_im, a_rkn_re, a_rkn_im} !==
              {R_W'(k), R_W'(-k), (k >= 64) ? {R_W'(k - 64), R_W'(64 - k)} : 16'h0}) begin
            n_fail++;
            $display("FAIL gap_pair k=%0d got %h/%h %h/%h", k, a_rk_re, a_rk_im, a_rkn_re, a_rkn_im);
          end
          n_tests++;
          if (a_primed !== (k >= 64) || a_idx !== 7'(k % 80)) begin
            n_fail++;
            $display("FAIL gap_meta k=%0d got p=%b idx=%0d exp p=%b idx=%0d",
                     k, a_primed, a_idx, (k >= 64), k % 80);
          end
        end
        k++;
      end else begin
        drive(1'b0, 8'hA5, 8'h5A, 1'b0);
        n_tests++;
        if (a_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_idle k=%0d got valid %b exp 0", k, a_valid);
        end
        if (k - 1 >= 64) begin
          n_tests++;
          if (a_rk_re !== R_W'(k - 1) || a_rkn_re !== R_W'(k - 65) || a_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_hold k=%0d got rk=%h rkn=%h p=%b exp %h %h 1",
                     k, a_rk_re, a_rkn_re, a_primed, R_W'(k - 1), R_W'(k - 65));
          end
        end
      end
    end
  endtask

  // sync_clear at sample 100 drops it and restarts priming
  task automatic test_sync_clear();
    int v;
    logic ev;
    do_reset();
    for (int k = 0; k < 100; k++) drive(1'b1, R_W'(k), R_W'(-k), 1'b0);
    n_tests++;
    if (a_primed !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre_primed got %b exp 1", a_primed);
    end
    drive(1'b1, R_W'(100), R_W'(-100), 1'b1);
    n_tests++;
    if ({a_valid, a_primed, a_rk_re, a_rk_im, a_rkn_re, a_rkn_im, a_idx} !== '0) begin
      n_fail++;
      $display("FAIL clr_state got v=%b p=%b rk=%h rkn=%h idx=%0d exp all 0",
               a_valid, a_primed, a_rk_re, a_rkn_re, a_idx);
    end
    for (int j = 0; j < 80; j++) begin
      v = 101 + j;
      drive(1'b1, R_W'(v), R_W'(-v), 1'b0);
      ev = ZF || (j >= 64);
      n_tests++;
      if (a_valid !== ev || a_primed !== (j >= 64)) begin
        n_fail++;
        $display("FAIL clr_refill j=%0d got v=%b p=%b exp v=%b p=%b", j, a_valid, a_primed, ev, (j >= 64));
      end
      if (ev) begin
        n_tests++;
        if ({a_rk_re, a_rkn_re, a_rkn_im, a_idx} !==
            {R_W'(v), (j >= 64) ? {R_W'(v - 64), R_W'(64 - v)} : 16'h0, 7'(j % 80)}) begin
          n_fail++;
          $display("FAIL clr_pair j=%0d got rk=%h rkn=%h/%h idx=%0d", j, a_rk_re, a_rkn_re, a_rkn_im, a_idx);
        end
      end
    end
  endtask

  // 240 samples: sample_idx wraps three times; N=48 pointer wrap is bit-exact
  task automatic test_wrap();
    logic ev;
    do_reset();
    for (int k = 0; k < 240; k++) begin
      drive(1'b1, R_W'(k), R_W'(-k), 1'b0);
      ev = ZF || (k >= 48);
      n_tests++;
      if (b_valid !== ev || b_primed !== (k >= 48)) begin
        n_fail++;
        $display("FAIL wrap_valid k=%0d got v=%b p=%b exp v=%b p=%b", k, b_valid, b_primed, ev, (k >= 48));
      end
      if (ev) begin
        n_tests++;
        if ({b_rk_re, b_rk_im, b_rkn_re, b_rkn_im} !==
            {R_W'(k), R_W'(-k), (k >= 48) ? {R_W'(k - 48), R_W'(48 - k)} : 16'h0}) begin
          n_fail++;
          $display("FAIL wrap_pair k=%0d got %h/%h %h/%h", k, b_rk_re, b_rk_im, b_rkn_re, b_rkn_im);
        end
        n_tests++;
        if (b_idx !== 7'(k % 80)) begin
          n_fail++;
          $display("FAIL wrap_idx k=%0d got %0d exp %0d", k, b_idx, k % 80);
        end
      end
      n_tests++;
      if (a_idx !== 7'(k % 80) && (ZF || k >= 64)) begin
        n_fail++;
        $display("FAIL wrap_idx_a k=%0d got %0d exp %0d", k, a_idx, k % 80);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gapped();
    test_sync_clear();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
